lcd1602_text_ctrl: RTL

Parametrised HD44780/LCD1602 text controller, successor to the fixed-message LCD test driver. Runs power-up wait and init sequence, then continuously refreshes both 16-character rows from an internal 32-byte character buffer that the host writes at any time. Supports 8-bit or 4-bit bus mode and configurable enable-pulse timing. Sits between game/UI logic and the LCD pins on the board top level.

---
 rtl/lcd1602_text_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lcd1602_text_ctrl.sv
// rtl/lcd1602_text_ctrl.sv - HD44780/LCD1602 init plus continuous two-row refresh from a host-written 32-byte buffer
// Define LCD_CURSOR_EN to initialise with cursor on and blinking.
module lcd1602_text_ctrl #(
  parameter int COUNT_MAX  = 8,
  parameter int BUS_WIDTH  = 8,
  parameter int POWER_WAIT = 2000000,
  parameter int CLEAR_WAIT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [7:0]           wr_data,
  output logic                 ready,
  output logic                 frame_done,
  output logic                 rs,
  output logic                 rw,
  output logic                 enable,
  output logic [BUS_WIDTH-1:0] data
);
`ifdef LCD_CURSOR_EN
  localparam logic [7:0] DISP_CMD = 8'h0F;
`else
  localparam logic [7:0] DISP_CMD = 8'h0C;
`endif
  localparam int WAIT_MAX = (POWER_WAIT > COUNT_MAX + CLEAR_WAIT) ? POWER_WAIT : COUNT_MAX + CLEAR_WAIT;
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] POWER_END = CW'(POWER_WAIT - 1);
  localparam logic [CW-1:0] PHASE_END = CW'(COUNT_MAX - 1);
  localparam logic [CW-1:0] CLEAR_END = CW'(COUNT_MAX + CLEAR_WAIT - 1);
  localparam logic [3:0]    INIT_LAST = (BUS_WIDTH == 4) ? 4'd4 : 4'd3;

  typedef enum logic [2:0] {POWER, INIT, ADDR0, ROW0, ADDR1, ROW1} state_t;
  state_t state, state_d;

  logic [7:0]    buffer [32];
  logic [CW-1:0] cnt, low_end;
  logic          hi, nib, single, single_d;
  logic [3:0]    idx, idx_d, init_step;
  logic [7:0]    cur, byte_d;
  logic          start, last_pulse, pulse_end, txn_end, frame_end;

  // One transaction is one or two enable pulses; the lone 4-bit init nibble is a single pulse.
  always_comb begin
    last_pulse = (BUS_WIDTH == 8) || single || nib;
    low_end    = (state == INIT && cur == 8'h01 && last_pulse) ? CLEAR_END : PHASE_END;
    pulse_end  = (state != POWER) && !hi && (cnt == low_end);
    txn_end    = pulse_end && last_pulse;
    state_d    = state;
    idx_d      = idx;
    start      = 1'b0;
    frame_end  = 1'b0;
    case (state)
      POWER: if (cnt == POWER_END) begin
        state_d = INIT;
        idx_d   = 4'd0;
        start   = 1'b1;
      end
      INIT: if (txn_end) begin
        start = 1'b1;
        if (idx == INIT_LAST) begin
          state_d = ADDR0;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx + 4'd1;
        end
      end
      ADDR0: if (txn_end) begin
        start   = 1'b1;
        state_d = ROW0;
      end
      ROW0: if (txn_end) begin
        start = 1'b1;
        idx_d = idx + 4'd1;
        if (idx == 4'd15) state_d = ADDR1;
      end
      ADDR1: if (txn_end) begin
        start   = 1'b1;
        state_d = ROW1;
      end
      ROW1: if (txn_end) begin
        start = 1'b1;
        idx_d = idx + 4'd1;
        if (idx == 4'd15) begin
          state_d   = ADDR0;
          frame_end = 1'b1;
        end
      end
      default: state_d = POWER;
    endcase
  end

  // Byte for the transaction that begins this edge; buffer reads see pre-write contents.
  always_comb begin
    init_step = (BUS_WIDTH == 4) ? idx_d : idx_d + 4'd1;
    single_d  = (BUS_WIDTH == 4) && (state_d == INIT) && (idx_d == 4'd0);
    byte_d    = 8'h20;
    case (state_d)
      INIT: case (init_step)
        4'd0:    byte_d = 8'h20;
        4'd1:    byte_d = (BUS_WIDTH == 4) ? 8'h28 : 8'h38;
        4'd2:    byte_d = DISP_CMD;
        4'd3:    byte_d = 8'h01;
        default: byte_d = 8'h06;
      endcase
      ADDR0:   byte_d = 8'h80;
      ADDR1:   byte_d = 8'hC0;
      ROW0:    byte_d = buffer[{1'b0, idx_d}];
      ROW1:    byte_d = buffer[{1'b1, idx_d}];
      default: byte_d = 8'h20;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= POWER;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) buffer[i] <= 8'h20;
      cnt        <= '0;
      hi         <= 1'b0;
      nib        <= 1'b0;
      single     <= 1'b0;
      idx        <= 4'd0;
      cur        <= 8'h00;
      enable     <= 1'b0;
      rs         <= 1'b0;
      data       <= '0;
      frame_done <= 1'b0;
    end else begin
      if (wr_en) buffer[wr_addr] <= wr_data;
      frame_done <= frame_end;
      idx        <= idx_d;
      if (start) begin
        cnt    <= '0;
        hi     <= 1'b1;
        nib    <= 1'b0;
        single <= single_d;
        cur    <= byte_d;
        enable <= 1'b1;
        rs     <= (state_d == ROW0) || (state_d == ROW1);
        data   <= byte_d[7 -: BUS_WIDTH];
      end else if (state == POWER) begin
        cnt <= cnt + CW'(1);
      end else if (hi) begin
        if (cnt == PHASE_END) begin
          hi     <= 1'b0;
          enable <= 1'b0;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (pulse_end) begin
        cnt    <= '0;
        hi     <= 1'b1;
        nib    <= 1'b1;
        enable <= 1'b1;
        data   <= cur[BUS_WIDTH-1:0];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign ready = (state != POWER) && (state != INIT);
  assign rw    = 1'b0;
endmodule
